gerador_pwm_posicao: RTL and testbench
======================================

# gerador_pwm_posicao

Consumer end of the sweep-position path: receives a position index (0..M-1) from the up/down sweep counter and drives the servo with a fixed-period PWM whose high time is linear in that position. New positions are double-buffered and take effect only at a period boundary, so a pulse is never truncated or stretched mid-period. The block sits between the sweep control FSM and the servo output pin.

## Interface
- M, 50: number of valid positions (0..M-1)
- N, 6: position width; 2^N ≥ M
- PERIODO, 1000000: PWM period in clock cycles (20 ms at 50 MHz)
- LARGURA_MIN, 50000: high time for position 0, in cycles; ≥ 1
- PASSO, 1000: additional high cycles per position step
- W, 20: period-counter width; constraint LARGURA_MIN + (M-1)·PASSO < PERIODO ≤ 2^W
- clock  in  1  system clock, rising edge
- zera_as_n  in  1  one clock; reset is asynchronous and active-low
- zera_s  in  1  synchronous clear, same effect as reset
- habilita  in  1  1 = generate PWM; 0 = hold idle
- carrega  in  1  load strobe, samples posicao
- posicao  in  N  requested position
- pwm  out  1  servo drive, from a flop
- posicao_atual  out  N  position governing the current period
- pendente  out  1  a loaded position awaits the next boundary
- aplicado  out  1  one-cycle pulse: posicao_atual just changed via load
- fim_periodo  out  1  high while cont == PERIODO-1

## Operation
- Reset/zera_s: cont=0, posicao_atual=0, reg_pend=0, pendente=0, pwm=0, aplicado=0; fim_periodo=0.
- Period counter cont (W bits): habilita=1 → increments each clock, PERIODO-1 wraps to 0; habilita=0 → forced to 0.
- Clamp: sampled posicao ≥ M is stored as M-1; no other error effect.
- carrega=1 (non-boundary edge): reg_pend ← clamp(posicao), pendente ← 1. Repeated loads: last wins.
- Boundary edge = edge where cont == PERIODO-1 with habilita=1, or any edge with habilita=0.
  - carrega=1 on that edge: posicao_atual ← clamp(posicao) directly (bypasses reg_pend); pendente ← 0; aplicado ← 1.
  - else if pendente: posicao_atual ← reg_pend; pendente ← 0; aplicado ← 1.
  - else: no change, aplicado ← 0.
- largura = LARGURA_MIN + posicao_atual·PASSO, computed in W bits (no overflow by constraint).
- pwm is high in cycle k of a period (k = cont value) iff habilita=1 and k < largura; pwm is a registered output, computed from next-state cont/posicao_atual so no extra latency is visible.
- aplicado is high exactly one cycle, coinciding with the first cycle (cont=0) using the new position.

## Timing
- habilita 0→1: first enabled cycle is cont=0 with pwm=1; pulse lasts largura cycles, then pwm=0 until cont wraps.
- Load latency: from carrega edge to effect ≤ PERIODO cycles; never affects the period in progress.
- habilita 1→0: next cycle pwm=0, cont=0, regardless of phase (servo pulse may be cut; intended).
- zera_as_n low: all outputs to reset values immediately, without a clock; release takes effect on the next edge.
- fim_periodo combinational from cont; high one cycle per period while enabled.

## Test plan
Params M=5, N=3, PERIODO=20, LARGURA_MIN=4, PASSO=2, W=5.
- Default run: reset, habilita=1, no load → pwm high cycles cont 0-3, low 4-19; fim_periodo every 20th cycle; posicao_atual=0.
- Deferred load: carrega, posicao=3 at cont=7 → pendente=1 through cont=19, current pulse stays 4; next period aplicado=1 at cont=0, posicao_atual=3, pwm high 10 cycles.
- Clamp and last-wins: load 1 at cont=2, then 7 at cont=5 → next period posicao_atual=4, pwm high 12 cycles.
- Boundary race: pendente holds 1, carrega posicao=2 at cont=19 → posicao_atual=2, pendente=0, aplicado=1, pwm high 8 cycles.
- Idle load: habilita=0 → pwm=0, cont=0; load 1 → posicao_atual=1 next edge, pendente stays 0; habilita=1 → 6-cycle pulse starting first enabled cycle.
- Async reset mid-pulse at cont=2, posicao_atual=3 → pwm=0, posicao_atual=0, pendente=0 with no clock edge; after release, 4-cycle pulses.

Source files
------------

// File: rtl/gerador_pwm_posicao_if.sv
// Control/status bundle between the sweep controller and the servo PWM generator.
// The master side drives habilita/carrega/posicao; the slave side is the generator.
interface gerador_pwm_posicao_if #(
    parameter int N = 6
);
    logic         habilita;
    logic         carrega;
    logic [N-1:0] posicao;
    logic         pwm;
    logic [N-1:0] posicao_atual;
    logic         pendente;
    logic         aplicado;
    logic         fim_periodo;

    modport master (
        output habilita, carrega, posicao,
        input  pwm, posicao_atual, pendente, aplicado, fim_periodo
    );

    modport slave (
        input  habilita, carrega, posicao,
        output pwm, posicao_atual, pendente, aplicado, fim_periodo
    );
endinterface

// File: rtl/gerador_pwm_posicao.sv
// Fixed-period servo PWM whose high time is linear in a double-buffered position;
// new positions only take effect at a period boundary so no pulse is cut or stretched.
module gerador_pwm_posicao #(
    parameter int M           = 50,
    parameter int N           = 6,
    parameter int PERIODO     = 1000000,
    parameter int LARGURA_MIN = 50000,
    parameter int PASSO       = 1000,
    parameter int W           = 20
) (
    input  logic                 clock,
    input  logic                 zera_as_n,
    input  logic                 zera_s,
    gerador_pwm_posicao_if.slave bus
);
    localparam logic [W-1:0] ULTIMO  = W'(PERIODO - 1);
    localparam logic [W-1:0] LMIN_W  = W'(LARGURA_MIN);
    localparam logic [W-1:0] PASSO_W = W'(PASSO);
    localparam logic [N-1:0] POS_MAX = N'(M - 1);

    logic [W-1:0] cont_reg, cont_next;
    logic [N-1:0] atual_reg, atual_next;
    logic [N-1:0] pend_val_reg, pend_val_next;
    logic         pend_reg, pend_next;
    logic         aplicado_reg, aplicado_next;
    logic         pwm_reg, pwm_next;
    logic         en_reg;

    logic [N-1:0] pos_clamp;
    logic         fronteira;
    logic [W-1:0] largura_next;

    // Out-of-range requests saturate to the last valid position.
    assign pos_clamp = (bus.posicao > POS_MAX) ? POS_MAX : bus.posicao;

    // While idle every edge is a boundary, so loads apply directly.
    assign fronteira = !bus.habilita || (cont_reg == ULTIMO);

    always_comb begin
        atual_next    = atual_reg;
        pend_val_next = pend_val_reg;
        pend_next     = pend_reg;
        aplicado_next = 1'b0;

        if (fronteira) begin
            if (bus.carrega) begin
                atual_next    = pos_clamp;
                pend_next     = 1'b0;
                aplicado_next = 1'b1;
            end else if (pend_reg) begin
                atual_next    = pend_val_reg;
                pend_next     = 1'b0;
                aplicado_next = 1'b1;
            end
        end else if (bus.carrega) begin
            pend_val_next = pos_clamp;
            pend_next     = 1'b1;
        end
    end

    // The first enabled edge parks the counter at 0 so the period opens with a full pulse.
    always_comb begin
        cont_next = '0;
        if (bus.habilita && en_reg && (cont_reg != ULTIMO)) begin
            cont_next = cont_reg + 1'b1;
        end
    end

    // pwm is registered but derived from next-state values, so it lines up with cont.
    assign largura_next = LMIN_W + W'(atual_next) * PASSO_W;
    assign pwm_next     = bus.habilita && (cont_next < largura_next);

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            cont_reg     <= '0;
            atual_reg    <= '0;
            pend_val_reg <= '0;
            pend_reg     <= 1'b0;
            aplicado_reg <= 1'b0;
            pwm_reg      <= 1'b0;
            en_reg       <= 1'b0;
        end else if (zera_s) begin
            cont_reg     <= '0;
            atual_reg    <= '0;
            pend_val_reg <= '0;
            pend_reg     <= 1'b0;
            aplicado_reg <= 1'b0;
            pwm_reg      <= 1'b0;
            en_reg       <= 1'b0;
        end else begin
            cont_reg     <= cont_next;
            atual_reg    <= atual_next;
            pend_val_reg <= pend_val_next;
            pend_reg     <= pend_next;
            aplicado_reg <= aplicado_next;
            pwm_reg      <= pwm_next;
            en_reg       <= bus.habilita;
        end
    end

    assign bus.pwm           = pwm_reg;
    assign bus.posicao_atual = atual_reg;
    assign bus.pendente      = pend_reg;
    assign bus.aplicado      = aplicado_reg;
    assign bus.fim_periodo   = (cont_reg == ULTIMO);

endmodule

// File: tb/tb_gerador_pwm_posicao.sv
// Scoreboard bench for gerador_pwm_posicao: a driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares them every cycle.
module tb_gerador_pwm_posicao;
    localparam int M           = 5;
    localparam int N           = 3;
    localparam int PERIODO     = 20;
    localparam int LARGURA_MIN = 4;
    localparam int PASSO       = 2;
    localparam int W           = 5;

    logic clock     = 1'b0;
    logic zera_as_n = 1'b1;
    logic zera_s    = 1'b0;

    gerador_pwm_posicao_if #(.N(N)) bus ();

    gerador_pwm_posicao #(
        .M(M), .N(N), .PERIODO(PERIODO), .LARGURA_MIN(LARGURA_MIN), .PASSO(PASSO), .W(W)
    ) dut (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .zera_s    (zera_s),
        .bus       (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         pwm;
        logic [N-1:0] atual;
        logic         pend;
        logic         apl;
        logic         fim;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: phase within the period, governing position, pending request.
    int m_phase, m_cur, m_pend, m_pval, m_en, m_apl, m_pwm;

    function automatic void check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.pwm   = (m_pwm != 0);
        o.atual = N'(m_cur);
        o.pend  = (m_pend != 0);
        o.apl   = (m_apl != 0);
        o.fim   = (m_phase == PERIODO - 1);
        return o;
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_cur = 0; m_pend = 0; m_pval = 0; m_en = 0; m_apl = 0; m_pwm = 0;
    endfunction

    // Apply inputs for the coming edge, predict the state after it, advance one clock.
    task automatic step(input bit hab, input bit car, input int pos, input bit zs);
        int clamp;
        bit boundary;
        bus.habilita = hab;
        bus.carrega  = car;
        bus.posicao  = N'(pos);
        zera_s       = zs;
        if (!zera_as_n || zs) begin
            model_reset();
        end else begin
            clamp    = (pos >= M) ? M - 1 : pos;
            boundary = !hab || (m_phase == PERIODO - 1);
            m_apl    = 0;
            if (boundary) begin
                if (car) begin
                    m_cur = clamp; m_pend = 0; m_apl = 1;
                end else if (m_pend != 0) begin
                    m_cur = m_pval; m_pend = 0; m_apl = 1;
                end
            end else if (car) begin
                m_pval = clamp; m_pend = 1;
            end
            m_phase = (hab && m_en != 0) ? (m_phase + 1) % PERIODO : 0;
            m_en    = hab;
            m_pwm   = (hab && (m_phase < LARGURA_MIN + m_cur * PASSO)) ? 1 : 0;
        end
        exp_q.push_back(model_obs());
        @(posedge clock);
        #1;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 3 * PERIODO && m_phase != target; i++) step(1, 0, 0, 0);
        check("run_to_phase", m_phase, target);
    endtask

    // Counts pwm-high cycles over one whole period starting at phase 0.
    task automatic period_hi(output int n);
        run_to(PERIODO - 1);
        n = 0;
        for (int i = 0; i < PERIODO; i++) begin
            step(1, 0, 0, 0);
            n += int'(bus.pwm);
        end
    endtask

    always @(negedge clock) begin
        obs_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            check("pwm",           int'(bus.pwm),           int'(e.pwm));
            check("posicao_atual", int'(bus.posicao_atual), int'(e.atual));
            check("pendente",      int'(bus.pendente),      int'(e.pend));
            check("aplicado",      int'(bus.aplicado),      int'(e.apl));
            check("fim_periodo",   int'(bus.fim_periodo),   int'(e.fim));
        end
    end

    initial begin
        int n;
        bit hab;
        model_reset();
        bus.habilita = 1'b0;
        bus.carrega  = 1'b0;
        bus.posicao  = '0;
        #1 zera_as_n = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        zera_as_n = 1'b1;
        $display("default run");
        step(1, 0, 0, 0);
        period_hi(n);
        check("default_width", n, 4);

        $display("deferred load 3 at cont=7");
        run_to(7);
        step(1, 1, 3, 0);
        check("deferred_pendente", int'(bus.pendente), 1);
        period_hi(n);
        check("deferred_width", n, 10);
        check("deferred_pos", int'(bus.posicao_atual), 3);

        $display("clamp and last-wins");
        run_to(2);
        step(1, 1, 1, 0);
        run_to(5);
        step(1, 1, 7, 0);
        period_hi(n);
        check("clamp_width", n, 12);
        check("clamp_pos", int'(bus.posicao_atual), 4);

        $display("boundary race");
        run_to(10);
        step(1, 1, 1, 0);
        run_to(19);
        step(1, 1, 2, 0);
        check("race_pos", int'(bus.posicao_atual), 2);
        check("race_pendente", int'(bus.pendente), 0);
        check("race_aplicado", int'(bus.aplicado), 1);
        n = int'(bus.pwm);
        for (int i = 1; i < PERIODO; i++) begin
            step(1, 0, 0, 0);
            n += int'(bus.pwm);
        end
        check("race_width", n, 8);

        $display("idle load");
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("idle_pwm", int'(bus.pwm), 0);
        step(0, 1, 1, 0);
        check("idle_pos", int'(bus.posicao_atual), 1);
        check("idle_pendente", int'(bus.pendente), 0);
        step(1, 0, 0, 0);
        n = int'(bus.pwm);
        for (int i = 1; i < PERIODO; i++) begin
            step(1, 0, 0, 0);
            n += int'(bus.pwm);
        end
        check("idle_width", n, 6);

        $display("async reset mid-pulse");
        run_to(5);
        step(1, 1, 3, 0);
        run_to(2);
        check("pre_reset_pwm", int'(bus.pwm), 1);
        zera_as_n = 1'b0;
        #1;
        check("async_pwm", int'(bus.pwm), 0);
        check("async_pos", int'(bus.posicao_atual), 0);
        check("async_pendente", int'(bus.pendente), 0);
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(model_obs());
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        zera_as_n = 1'b1;
        step(1, 0, 0, 0);
        period_hi(n);
        check("post_reset_width", n, 4);

        $display("random run");
        for (int i = 0; i < 600; i++) begin
            hab = ($urandom_range(0, 15) != 0);
            step(hab, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 149) == 0));
        end

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
